cpu_store_buffer: RTL and testbench

- Store buffer upstream of the commit stage; sole driver of the commit stage's cache request fields (read, write, mode, addr, data in).
- Queues retired stores in a FIFO and drains them to the cache one at a time.
- Serves loads by store-to-load forwarding when possible; otherwise issues a cache read.
- Arbitrates the single cache port between load reads and store drains.

---
 rtl/cpu_store_buffer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cpu_store_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_store_buffer.sv
// cpu_store_buffer
// Store buffer in front of the commit stage. Retired stores queue in a small
// FIFO and drain to the cache one at a time; loads are satisfied by
// store-to-load forwarding when the youngest matching entry allows it,
// otherwise they take the single cache port through a read.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no cache access; evaluates loads, forwarding and drains
// S_LOAD  | cache read for the pending load, waiting for cache_hit
// S_STORE | cache write of the head entry, waiting for cache_hit
module cpu_store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_st_valid,
  input  logic [ADDR_WIDTH-1:0] i_st_addr,
  input  logic [DATA_WIDTH-1:0] i_st_data,
  input  logic                  i_st_mode,
  output logic                  o_st_ready,
  input  logic                  i_ld_valid,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic                  i_ld_mode,
  output logic                  o_ld_done,
  output logic [DATA_WIDTH-1:0] o_ld_data,
  output logic                  o_empty,
  output logic                  o_cache_read,
  output logic                  o_cache_write,
  output logic                  o_cache_mode,
  output logic [ADDR_WIDTH-1:0] o_cache_addr,
  output logic [DATA_WIDTH-1:0] o_cache_data_in,
  input  logic                  i_cache_hit,
  input  logic [DATA_WIDTH-1:0] i_cache_data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  // FIFO storage
  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic                  r_mode [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  // FSM and registered cache request
  state_t                r_state;
  logic                  r_cache_read;
  logic                  r_cache_write;
  logic                  r_cache_mode;
  logic [ADDR_WIDTH-1:0] r_cache_addr;
  logic [DATA_WIDTH-1:0] r_cache_data_in;

  // Load result
  logic                  r_ld_done;
  logic [DATA_WIDTH-1:0] r_ld_data;

  // Combinational next values
  state_t                w_nxt_state;
  logic                  w_nxt_read;
  logic                  w_nxt_write;
  logic                  w_nxt_mode;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic [DATA_WIDTH-1:0] w_nxt_data_in;
  logic                  w_fwd_fire;
  logic                  w_load_fire;
  logic                  w_pop;

  logic                  w_push;
  logic                  w_ld_req;
  logic                  w_match;
  logic [PTR_W-1:0]      w_young;
  logic [PTR_W-1:0]      w_idx;
  logic                  w_fwd_hit;
  logic                  w_conflict;
  logic [DATA_WIDTH-1:0] w_fwd_data;
  logic [DATA_WIDTH-1:0] w_lane_shift;

  assign o_st_ready = (r_count < FULL_CNT);
  assign w_push     = i_st_valid && o_st_ready;
  // A load is not re-served in the cycle its completion pulse is visible.
  assign w_ld_req   = i_ld_valid && !r_ld_done;
  assign o_empty    = (r_count == '0) && (r_state == S_IDLE);

  assign o_ld_done       = r_ld_done;
  assign o_ld_data       = r_ld_data;
  assign o_cache_read    = r_cache_read;
  assign o_cache_write   = r_cache_write;
  assign o_cache_mode    = r_cache_mode;
  assign o_cache_addr    = r_cache_addr;
  assign o_cache_data_in = r_cache_data_in;

  // Find the youngest valid entry whose word address matches the load.
  always_comb begin
    w_match = 1'b0;
    w_young = '0;
    w_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if ((k < int'(r_count)) &&
          (r_addr[w_idx][ADDR_WIDTH-1:2] == i_ld_addr[ADDR_WIDTH-1:2])) begin
        w_match = 1'b1;
        w_young = w_idx;
      end
    end
  end

  // Decide whether the youngest match can forward, and what it forwards.
  always_comb begin
    w_fwd_hit    = 1'b0;
    w_conflict   = 1'b0;
    w_fwd_data   = '0;
    w_lane_shift = r_data[w_young] >> {i_ld_addr[1:0], 3'b000};
    if (w_match) begin
      if (!r_mode[w_young]) begin
        w_fwd_hit = 1'b1;
        if (!i_ld_mode) w_fwd_data = r_data[w_young];
        else            w_fwd_data = {{(DATA_WIDTH-8){1'b0}}, w_lane_shift[7:0]};
      end else if (i_ld_mode && (r_addr[w_young] == i_ld_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = {{(DATA_WIDTH-8){1'b0}}, r_data[w_young][7:0]};
      end else begin
        w_conflict = 1'b1;
      end
    end
  end

  // Next state and next registered cache request.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_read    = r_cache_read;
    w_nxt_write   = r_cache_write;
    w_nxt_mode    = r_cache_mode;
    w_nxt_addr    = r_cache_addr;
    w_nxt_data_in = r_cache_data_in;
    w_fwd_fire    = 1'b0;
    w_load_fire   = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nxt_read    = 1'b0;
        w_nxt_write   = 1'b0;
        w_nxt_mode    = 1'b0;
        w_nxt_addr    = '0;
        w_nxt_data_in = '0;
        if ((r_count == FULL_CNT) || (w_ld_req && w_conflict)) begin
          w_nxt_state   = S_STORE;
          w_nxt_write   = 1'b1;
          w_nxt_mode    = r_mode[r_head];
          w_nxt_addr    = r_addr[r_head];
          w_nxt_data_in = r_data[r_head];
        end else if (w_ld_req && !w_push && !w_match) begin
          w_nxt_state = S_LOAD;
          w_nxt_read  = 1'b1;
          w_nxt_mode  = i_ld_mode;
          w_nxt_addr  = i_ld_addr;
        end else if (w_ld_req && !w_push && w_fwd_hit) begin
          w_fwd_fire = 1'b1;
        end else if (r_count != '0) begin
          w_nxt_state   = S_STORE;
          w_nxt_write   = 1'b1;
          w_nxt_mode    = r_mode[r_head];
          w_nxt_addr    = r_addr[r_head];
          w_nxt_data_in = r_data[r_head];
        end
      end
      S_LOAD: begin
        if (i_cache_hit) begin
          w_load_fire   = 1'b1;
          w_nxt_state   = S_IDLE;
          w_nxt_read    = 1'b0;
          w_nxt_write   = 1'b0;
          w_nxt_mode    = 1'b0;
          w_nxt_addr    = '0;
          w_nxt_data_in = '0;
        end
      end
      S_STORE: begin
        if (i_cache_hit) begin
          w_pop         = 1'b1;
          w_nxt_state   = S_IDLE;
          w_nxt_read    = 1'b0;
          w_nxt_write   = 1'b0;
          w_nxt_mode    = 1'b0;
          w_nxt_addr    = '0;
          w_nxt_data_in = '0;
        end
      end
      default: begin
        w_nxt_state   = S_IDLE;
        w_nxt_read    = 1'b0;
        w_nxt_write   = 1'b0;
        w_nxt_mode    = 1'b0;
        w_nxt_addr    = '0;
        w_nxt_data_in = '0;
      end
    endcase
  end

  // State register and registered cache request.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_cache_read    <= 1'b0;
      r_cache_write   <= 1'b0;
      r_cache_mode    <= 1'b0;
      r_cache_addr    <= '0;
      r_cache_data_in <= '0;
    end else begin
      r_state         <= w_nxt_state;
      r_cache_read    <= w_nxt_read;
      r_cache_write   <= w_nxt_write;
      r_cache_mode    <= w_nxt_mode;
      r_cache_addr    <= w_nxt_addr;
      r_cache_data_in <= w_nxt_data_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload write at the tail; contents need no reset since count gates them.
  always_ff @(posedge i_clock) begin
    if (w_push && !i_reset) begin
      r_addr[r_tail] <= i_st_addr;
      r_data[r_tail] <= i_st_data;
      r_mode[r_tail] <= i_st_mode;
    end
  end

  // Load completion: forwarded data or cache read data, one-cycle pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ld_done <= 1'b0;
      r_ld_data <= '0;
    end else if (w_fwd_fire) begin
      r_ld_done <= 1'b1;
      r_ld_data <= w_fwd_data;
    end else if (w_load_fire) begin
      r_ld_done <= 1'b1;
      r_ld_data <= i_cache_data_out;
    end else begin
      r_ld_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_store_buffer.sv
// Directed bench for cpu_store_buffer: store drain, forwarding, conflicts,
// full-buffer priority, youngest-match selection and reset abandonment.
module tb_cpu_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_mode;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_mode;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        empty;
  logic        cache_read;
  logic        cache_write;
  logic        cache_mode;
  logic [31:0] cache_addr;
  logic [31:0] cache_data_in;
  logic        cache_hit;
  logic [31:0] cache_data_out;

  int checks   = 0;
  int failures = 0;

  cpu_store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .i_clock         (clock),
    .i_reset         (reset),
    .i_st_valid      (st_valid),
    .i_st_addr       (st_addr),
    .i_st_data       (st_data),
    .i_st_mode       (st_mode),
    .o_st_ready      (st_ready),
    .i_ld_valid      (ld_valid),
    .i_ld_addr       (ld_addr),
    .i_ld_mode       (ld_mode),
    .o_ld_done       (ld_done),
    .o_ld_data       (ld_data),
    .o_empty         (empty),
    .o_cache_read    (cache_read),
    .o_cache_write   (cache_write),
    .o_cache_mode    (cache_mode),
    .o_cache_addr    (cache_addr),
    .o_cache_data_in (cache_data_in),
    .i_cache_hit     (cache_hit),
    .i_cache_data_out(cache_data_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic m);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mode  = m;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_mode = 0;
    ld_valid = 0; ld_addr = 0; ld_mode = 0; cache_hit = 0; cache_data_out = 0;
    tick(); tick();
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_cache_read", 32'(cache_read), 32'd0);
    chk("rst_cache_write", 32'(cache_write), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_cache_addr", cache_addr, 32'd0);
    reset = 1'b0;

    // 1: single word store drains
    push(32'h100, 32'hDEADBEEF, 1'b0);
    chk("t1_not_empty", 32'(empty), 32'd0);
    tick();
    chk("t1_write", 32'(cache_write), 32'd1);
    chk("t1_read", 32'(cache_read), 32'd0);
    chk("t1_addr", cache_addr, 32'h100);
    chk("t1_data", cache_data_in, 32'hDEADBEEF);
    chk("t1_mode", 32'(cache_mode), 32'd0);
    cache_hit = 1'b1;
    tick();
    cache_hit = 1'b0;
    chk("t1_write_off", 32'(cache_write), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);

    // 2: byte load forwarded from a word entry
    push(32'h200, 32'h11223344, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h202; ld_mode = 1'b1;
    tick();
    chk("t2_ld_done", 32'(ld_done), 32'd1);
    chk("t2_ld_data", ld_data, 32'h00000022);
    chk("t2_no_read", 32'(cache_read), 32'd0);
    ld_valid = 1'b0;
    tick();
    chk("t2_done_pulse", 32'(ld_done), 32'd0);
    chk("t2_drain_write", 32'(cache_write), 32'd1);
    chk("t2_drain_addr", cache_addr, 32'h200);
    cache_hit = 1'b1;
    tick();
    cache_hit = 1'b0;
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: word load conflicting with a byte entry waits for the drain
    push(32'h300, 32'h000000AB, 1'b1);
    ld_valid = 1'b1; ld_addr = 32'h300; ld_mode = 1'b0;
    tick();
    chk("t3_store_first", 32'(cache_write), 32'd1);
    chk("t3_no_read", 32'(cache_read), 32'd0);
    chk("t3_addr", cache_addr, 32'h300);
    chk("t3_mode", 32'(cache_mode), 32'd1);
    chk("t3_data", cache_data_in, 32'h000000AB);
    tick();
    chk("t3_still_store", 32'(cache_read), 32'd0);
    chk("t3_no_done", 32'(ld_done), 32'd0);
    cache_hit = 1'b1;
    tick();
    cache_hit = 1'b0;
    chk("t3_idle_read", 32'(cache_read), 32'd0);
    chk("t3_idle_write", 32'(cache_write), 32'd0);
    tick();
    chk("t3_load_read", 32'(cache_read), 32'd1);
    chk("t3_load_addr", cache_addr, 32'h300);
    chk("t3_load_mode", 32'(cache_mode), 32'd0);
    cache_hit = 1'b1; cache_data_out = 32'hCAFEF00D;
    tick();
    cache_hit = 1'b0;
    chk("t3_ld_done", 32'(ld_done), 32'd1);
    chk("t3_ld_data", ld_data, 32'hCAFEF00D);
    chk("t3_read_off", 32'(cache_read), 32'd0);
    ld_valid = 1'b0;
    tick();
    chk("t3_done_pulse", 32'(ld_done), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);

    // 4: fill to DEPTH; full buffer drains before an unrelated load
    for (int k = 0; k < 4; k++) push(32'h500 + 32'(4 * k), 32'(k + 1), 1'b0);
    chk("t4_full_ready", 32'(st_ready), 32'd0);
    chk("t4_write", 32'(cache_write), 32'd1);
    chk("t4_head_addr", cache_addr, 32'h500);
    ld_valid = 1'b1; ld_addr = 32'h600; ld_mode = 1'b0;
    tick();
    chk("t4_ld_wait", 32'(ld_done), 32'd0);
    chk("t4_no_read", 32'(cache_read), 32'd0);
    cache_hit = 1'b1;
    tick();
    cache_hit = 1'b0;
    chk("t4_ready_again", 32'(st_ready), 32'd1);
    tick();
    chk("t4_load_read", 32'(cache_read), 32'd1);
    chk("t4_load_addr", cache_addr, 32'h600);
    chk("t4_load_nowrite", 32'(cache_write), 32'd0);
    cache_hit = 1'b1; cache_data_out = 32'h12345678;
    tick();
    cache_hit = 1'b0;
    chk("t4_ld_done", 32'(ld_done), 32'd1);
    chk("t4_ld_data", ld_data, 32'h12345678);
    ld_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t4_drain_addr", cache_addr, 32'h500 + 32'(4 * k));
      chk("t4_drain_data", cache_data_in, 32'(k + 1));
      cache_hit = 1'b1;
      tick();
      cache_hit = 1'b0;
    end
    chk("t4_empty", 32'(empty), 32'd1);

    // 5: youngest of two matching word entries forwards
    push(32'h700, 32'h00000077, 1'b0);
    push(32'h400, 32'h00000001, 1'b0);
    push(32'h400, 32'h00000002, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h400; ld_mode = 1'b0;
    chk("t5_draining", cache_addr, 32'h700);
    cache_hit = 1'b1;
    tick();
    cache_hit = 1'b0;
    chk("t5_no_done_yet", 32'(ld_done), 32'd0);
    tick();
    chk("t5_ld_done", 32'(ld_done), 32'd1);
    chk("t5_ld_data", ld_data, 32'h00000002);
    chk("t5_no_read", 32'(cache_read), 32'd0);
    ld_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      tick();
      chk("t5_drain_addr", cache_addr, 32'h400);
      chk("t5_drain_data", cache_data_in, 32'(k));
      cache_hit = 1'b1;
      tick();
      cache_hit = 1'b0;
    end
    chk("t5_empty", 32'(empty), 32'd1);

    // 6: reset during LOAD abandons the access
    ld_valid = 1'b1; ld_addr = 32'h800; ld_mode = 1'b0;
    tick();
    chk("t6_load_read", 32'(cache_read), 32'd1);
    reset = 1'b1; cache_hit = 1'b1; cache_data_out = 32'h55555555;
    tick();
    chk("t6_rst_read", 32'(cache_read), 32'd0);
    chk("t6_rst_addr", cache_addr, 32'd0);
    chk("t6_rst_done", 32'(ld_done), 32'd0);
    chk("t6_rst_data", ld_data, 32'd0);
    chk("t6_rst_ready", 32'(st_ready), 32'd1);
    chk("t6_rst_empty", 32'(empty), 32'd1);
    reset = 1'b0; ld_valid = 1'b0;
    tick();
    chk("t6_no_done1", 32'(ld_done), 32'd0);
    tick();
    chk("t6_no_done2", 32'(ld_done), 32'd0);
    chk("t6_idle_read", 32'(cache_read), 32'd0);
    cache_hit = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
